fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer for the 4-bit CPU: the producer side of the opcode interface that the decoder consumes. It owns the program counter, reads 8-bit instruction words from instruction memory over a req/ack handshake, and presents the opcode to the decoder. It then advances, holds, or stops according to the decoder's `pc_inc` and `halt` outputs. It sits between instruction memory and the decoder/datapath.

## Interface
Parameters:
- `ADDR_W`, default 4: program counter / instruction memory address width (16 words).
- `CNT_W`, default 8: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: system clock, all state updates on rising edge.
- `rst`, in, 1: one clock; reset is asynchronous and active-high.
- `start`, in, 1: begin execution at address 0. Honoured only in IDLE or HALTED.
- `imem_req`, out, 1: instruction read request.
- `imem_addr`, out, `ADDR_W`: read address, equal to `pc` whenever `imem_req`=1.
- `imem_ack`, in, 1: read complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`, in, 8: instruction word. [7:4] opcode, [3:0] operand.
- `dec_pc_inc`, in, 1: decoder `pc_inc` for the presented opcode.
- `dec_halt`, in, 1: decoder `halt` for the presented opcode.
- `stall`, in, 1: datapath busy; freezes EXEC.
- `opcode`, out, 4: registered opcode to the decoder.
- `operand`, out, 4: registered operand to the datapath.
- `instr_valid`, out, 1: high in EXEC (opcode/operand are live).
- `pc`, out, `ADDR_W`: program counter.
- `running`, out, 1: high in FETCH or EXEC.
- `halted`, out, 1: high in HALTED.
- `retired`, out, `CNT_W`: instructions completed since last start. Saturating.

## Operation
- States: IDLE, FETCH, EXEC, HALTED. Encoding is free.
- Reset (async, immediate):
  - State goes to IDLE.
  - `pc`=0, `opcode`=4'b0000 (NOP), `operand`=0.
  - `imem_req`=0, `instr_valid`=0, `running`=0, `halted`=0, `retired`=0.
- IDLE:
  - Outputs are quiescent.
  - On `start`=1: `pc`←0, `retired`←0, go to FETCH.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`, held stable until ack.
  - On `imem_ack`=1: `opcode`←`imem_rdata[7:4]`, `operand`←`imem_rdata[3:0]`, go to EXEC.
  - Without ack: stay. `opcode`/`operand` keep their previous values.
- EXEC (`instr_valid`=1). Priority order:
  1. `stall`=1: hold everything.
  2. `dec_halt`=1: go to HALTED. `pc` unchanged; `retired`+1.
  3. `dec_pc_inc`=1: `pc`←`pc`+1 modulo 2^`ADDR_W` (15→0 for default); `retired`+1; go to FETCH.
  4. Otherwise: hold in EXEC, same as a stall.
- HALTED:
  - `halted`=1. `opcode` keeps the HALT opcode so the decoder keeps asserting `halt`.
  - On `start`=1: `pc`←0, `retired`←0, go to FETCH.
- Boundary rules:
  - `start` in FETCH or EXEC: ignored.
  - `imem_ack` outside FETCH: ignored; no register changes.
  - `dec_halt` and `dec_pc_inc` both high: halt wins.
  - `retired` saturates at 2^`CNT_W`−1 and does not wrap.
  - Reset during FETCH: `imem_req` drops asynchronously, with no latch of any pending data.

## Timing
- FETCH→EXEC occurs on the edge that samples `imem_ack`=1. Ack may be combinational in the request cycle, giving a zero-wait fetch of 1 cycle.
- Minimum throughput: 2 cycles per instruction (1 FETCH + 1 EXEC).
- Each wait-state cycle adds 1; each `stall` cycle adds 1.
- `start` sampled at edge N: `imem_req`=1 in cycle N+1.
- `dec_pc_inc`/`dec_halt` are sampled only in EXEC. They are combinational from `opcode`, and `opcode` is stable throughout EXEC.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.

## Test plan
- Reset values: assert `rst` mid-cycle. All outputs must go to reset values immediately (state IDLE, `opcode`=0000, `pc`=0, `imem_req`=0). Release, hold `start`=0 for 5 cycles: nothing changes.
- Zero-wait program: memory = 0x1A, 0x93, 0x35, 0x2C, 0xF0 with the real decoder attached, pulse `start`. Required:
  - `opcode` = 1, 9, 3, 2, F in EXEC cycles 2, 4, 6, 8, 10 after start.
  - `halted`=1 from cycle 11.
  - `pc`=4, `retired`=5.
- Wait states: ack delayed 3 cycles on address 2. `imem_req` and `imem_addr`=2 must be held 4 cycles, and `opcode` must be unchanged until the ack edge.
- Stall: `stall`=1 for 2 cycles during ADD (0x35) EXEC. `instr_valid` must stay high 3 cycles; `pc` stays 2; `retired` is not incremented until stall drops.
- Wrap: 16 NOP words (0x00). After 16 instructions `pc` must return to 0 (15→0) and `imem_addr`=0 must be requested again; `retired`=16.
- Restart and reset mid-run:
  - `start` while running: must be ignored.
  - `start` in HALTED: `pc`=0 and FETCH on the next cycle.
  - `rst` during FETCH: `imem_req` must drop immediately, and an ack arriving after reset must not load `opcode`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory over req/ack and presents opcode/operand to the decoder.
// Latency: 1 FETCH cycle plus memory wait states, then at least 1 EXEC cycle. Backpressure: req/addr held until ack; stall freezes EXEC.
// All outputs are registered or decoded from state, so no input reaches an output combinationally.
module fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    input  logic              dec_pc_inc,
    input  logic              dec_halt,
    input  logic              stall,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] retired_inc;

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    assign retired_inc = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= '0;
            opcode  <= 4'b0000;
            operand <= 4'b0000;
            retired <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        opcode  <= imem_rdata[7:4];
                        operand <= imem_rdata[3:0];
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Halt has priority over pc_inc; neither is acted on while stalled.
                    if (!stall) begin
                        if (dec_halt) begin
                            retired <= retired_inc;
                            state   <= ST_HALTED;
                        end else if (dec_pc_inc) begin
                            pc      <= pc + ADDR_W'(1);
                            retired <= retired_inc;
                            state   <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_EXEC);
    assign running     = (state == ST_FETCH) || (state == ST_EXEC);
    assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory and a minimal decoder (opcode F halts, others advance).
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       dec_pc_inc;
    logic       dec_halt;
    logic       stall;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_valid;
    logic [3:0] pc;
    logic       running;
    logic       halted;
    logic [7:0] retired;

    logic [7:0] mem [16];
    int         wait_addr;
    int         wait_n;
    int         wait_cnt;
    int         delay;
    logic       ack_en;
    logic       ack_force;
    logic [7:0] force_dat;
    logic       force_inc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_op [5];

    fetch_unit #(.ADDR_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dec_pc_inc (dec_pc_inc),
        .dec_halt   (dec_halt),
        .stall      (stall),
        .opcode     (opcode),
        .operand    (operand),
        .instr_valid(instr_valid),
        .pc         (pc),
        .running    (running),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    assign dec_halt   = (opcode == 4'hF);
    assign dec_pc_inc = !dec_halt || force_inc;

    // Memory answers combinationally unless the current address is programmed with wait states.
    always_comb begin
        delay      = (int'(imem_addr) == wait_addr) ? wait_n : 0;
        imem_ack   = ack_force || (ack_en && imem_req && (wait_cnt >= delay));
        imem_rdata = ack_force ? force_dat : mem[imem_addr];
    end

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stall     = 1'b0;
        ack_en    = 1'b1;
        ack_force = 1'b0;
        force_dat = 8'h00;
        force_inc = 1'b0;
        wait_addr = -1;
        wait_n    = 0;
        wait_cnt  = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h1A; mem[1] = 8'h93; mem[2] = 8'h35; mem[3] = 8'h2C; mem[4] = 8'hF0;
        exp_op[0] = 4'h1; exp_op[1] = 4'h9; exp_op[2] = 4'h3; exp_op[3] = 4'h2; exp_op[4] = 4'hF;

        // Reset values, then idle with start low.
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_opcode", opcode, 0);
        check("rst_pc", pc, 0);
        check("rst_valid", instr_valid, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_running", running, 0);
        check("idle_halted", halted, 0);
        check("idle_req", imem_req, 0);
        check("idle_retired", retired, 0);

        // Zero-wait program: opcode in EXEC on even cycles after start, halted from cycle 11.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zw_req_c1", imem_req, 1);
        check("zw_addr_c1", imem_addr, 0);
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                check("zw_valid", instr_valid, 1);
                check("zw_opcode", opcode, exp_op[c/2-1]);
            end
        end
        check("zw_halted", halted, 1);
        check("zw_pc", pc, 4);
        check("zw_retired", retired, 5);
        check("zw_hold_op", opcode, 4'hF);

        // Restart from HALTED with 3 wait states on address 2, then stall the ADD.
        wait_addr = 2;
        wait_n    = 3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rs_pc", pc, 0);
        check("rs_req", imem_req, 1);
        check("rs_retired", retired, 0);
        check("rs_halted", halted, 0);
        repeat (4) @(negedge clk);
        check("ws_req_c5", imem_req, 1);
        check("ws_addr_c5", imem_addr, 2);
        check("ws_op_c5", opcode, 4'h9);
        @(negedge clk);
        start = 1'b1;
        check("ws_addr_c6", imem_addr, 2);
        @(negedge clk);
        start = 1'b0;
        check("ws_req_c7", imem_req, 1);
        check("ws_addr_c7", imem_addr, 2);
        check("ws_op_c7", opcode, 4'h9);
        @(negedge clk);
        check("ws_req_c8", imem_req, 1);
        check("ws_op_c8", opcode, 4'h9);
        @(negedge clk);
        check("ws_valid_c9", instr_valid, 1);
        check("ws_op_c9", opcode, 4'h3);
        check("ws_operand_c9", operand, 4'h5);
        stall = 1'b1;
        @(negedge clk);
        check("st_valid_c10", instr_valid, 1);
        check("st_pc_c10", pc, 2);
        check("st_ret_c10", retired, 2);
        start     = 1'b1;
        ack_force = 1'b1;
        force_dat = 8'h77;
        @(negedge clk);
        start     = 1'b0;
        ack_force = 1'b0;
        stall     = 1'b0;
        check("st_valid_c11", instr_valid, 1);
        check("st_pc_c11", pc, 2);
        check("st_ret_c11", retired, 2);
        check("st_op_c11", opcode, 4'h3);
        check("st_operand_c11", operand, 4'h5);
        @(negedge clk);
        check("st_pc_c12", pc, 3);
        check("st_ret_c12", retired, 3);
        check("st_req_c12", imem_req, 1);
        force_inc = 1'b1;
        repeat (3) @(negedge clk);
        check("hw_valid_c15", instr_valid, 1);
        check("hw_op_c15", opcode, 4'hF);
        @(negedge clk);
        check("hw_halted", halted, 1);
        check("hw_pc", pc, 4);
        check("hw_retired", retired, 5);
        force_inc = 1'b0;

        // Wrap: 16 NOPs bring the PC from 15 back to 0.
        wait_addr = -1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        check("wr_valid_c32", instr_valid, 1);
        check("wr_pc_c32", pc, 15);
        check("wr_ret_c32", retired, 15);
        @(negedge clk);
        check("wr_pc_c33", pc, 0);
        check("wr_req_c33", imem_req, 1);
        check("wr_addr_c33", imem_addr, 0);
        check("wr_ret_c33", retired, 16);

        // Retired counter saturates.
        repeat (600) @(negedge clk);
        check("sat_retired", retired, 255);
        check("sat_running", running, 1);

        // Reset mid-cycle while parked in FETCH; a late ack must not load.
        for (int i = 0; i < 16; i++) mem[i] = 8'h5A;
        repeat (4) @(negedge clk);
        check("pre_rst_op", opcode, 4'h5);
        ack_en = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_req", imem_req, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_opcode", opcode, 0);
        check("arst_pc", pc, 0);
        check("arst_retired", retired, 0);
        check("arst_running", running, 0);
        @(negedge clk);
        rst       = 1'b0;
        ack_en    = 1'b1;
        ack_force = 1'b1;
        force_dat = 8'h5A;
        repeat (2) @(negedge clk);
        check("late_ack_op", opcode, 0);
        check("late_ack_operand", operand, 0);
        check("late_ack_req", imem_req, 0);
        ack_force = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_pc", pc, 0);
        check("post_rst_running", running, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
